// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Converts one layer's parallel neuron outputs into a serial word stream
//   for the next layer. A frame is captured when in_valid[0] is high. Its
//   words are then presented one per clock, neuron 0 first, with a valid
//   strobe and a last-word flag. There is no backpressure on either side.
//
//   Optional feature: define SER_DBUF_EN to add one pending frame buffer.
//   With the pending buffer, a capture that arrives while a frame is being
//   emitted is held in that buffer and follows the current frame with no gap.
//   Without it, such a capture is discarded and counted.
//
//   Ports:
//     clk        clock, all state on rising edge
//     rst        asynchronous, active-high reset
//     in_valid   per-neuron valid; only bit 0 keys a capture
//     in_data    NN words, word i at in_data[i*dataWidth +: dataWidth]
//     out_valid  high while a word is presented
//     out_data   current word; holds its value when out_valid is low
//     out_last   high with word NN-1 of a frame
//     busy       out_valid | pending flag
//     drop_cnt   saturating count of discarded frames
//
//   state | meaning
//   IDLE  | nothing presented, waiting for a capture
//   SHIFT | presenting word index_q of the frame in shift_q

module layer_output_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    parameter int DROP_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int IDX_W = (NN > 2) ? $clog2(NN) : 1;

    localparam logic [0:0]        IDLE     = 1'b0;
    localparam logic [0:0]        SHIFT    = 1'b1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [0:0]              state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [NN*dataWidth-1:0] shift_q, shift_d;
    logic                    out_valid_q, out_valid_d;
    logic [dataWidth-1:0]    out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [DROP_W-1:0]       drop_q, drop_d;

    logic                    capture;
    logic                    retire;
    logic                    load_en;
    logic                    drop_inc;
    logic [NN*dataWidth-1:0] load_frame;
    logic [IDX_W-1:0]        index_nxt;
    logic                    pend_flag;

    // Neurons fire in lockstep, so only bit 0 is meaningful.
    logic unused_in_valid;
    assign unused_in_valid = ^in_valid[NN-1:1];

    assign capture   = in_valid[0];
    assign retire    = (state_q == SHIFT) && (index_q == LAST_IDX);
    assign index_nxt = index_q + IDX_ONE;

`ifdef SER_DBUF_EN
    logic [NN*dataWidth-1:0] pend_buf_q, pend_buf_d;
    logic                    pend_q, pend_d;
    assign pend_flag = pend_q;
`else
    assign pend_flag = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        shift_d     = shift_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        drop_d      = drop_q;
        drop_inc    = 1'b0;
        load_en     = 1'b0;
        load_frame  = in_data;
`ifdef SER_DBUF_EN
        pend_buf_d  = pend_buf_q;
        pend_d      = pend_q;
`endif
        case (state_q)
            IDLE: begin
                load_en = capture;
            end
            SHIFT: begin
                if (!retire) begin
                    index_d    = index_nxt;
                    shift_d    = shift_q >> dataWidth;
                    out_data_d = shift_q[2*dataWidth-1 -: dataWidth];
                    out_last_d = (index_nxt == LAST_IDX);
                    if (capture) begin
`ifdef SER_DBUF_EN
                        if (!pend_q) begin
                            pend_d     = 1'b1;
                            pend_buf_d = in_data;
                        end else begin
                            drop_inc = 1'b1;
                        end
`else
                        drop_inc = 1'b1;
`endif
                    end
                end else begin
`ifdef SER_DBUF_EN
                    // Pending frame goes first; a simultaneous capture
                    // refills the slot it just vacated.
                    if (pend_q) begin
                        load_en    = 1'b1;
                        load_frame = pend_buf_q;
                        pend_d     = capture;
                        if (capture) begin
                            pend_buf_d = in_data;
                        end
                    end else
`endif
                    if (capture) begin
                        load_en = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        index_d     = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d     = SHIFT;
            index_d     = '0;
            shift_d     = load_frame;
            out_valid_d = 1'b1;
            out_data_d  = load_frame[dataWidth-1:0];
            out_last_d  = 1'b0;
        end

        if (drop_inc && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
        end
    end

`ifdef SER_DBUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_buf_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            pend_buf_q <= pend_buf_d;
            pend_q     <= pend_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = out_valid_q | pend_flag;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int DROP_W = 8;

    logic               clk;
    logic               rst;
    logic [NN-1:0]      in_valid;
    logic [NN*DW-1:0]   in_data;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic               busy;
    logic [DROP_W-1:0]  drop_cnt;

    int checks;
    int errors;

    layer_output_serializer #(.NN(NN), .dataWidth(DW), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_frame(input logic [DW-1:0] base);
        for (int i = 0; i < NN; i++) begin
            in_data[i*DW +: DW] = base + DW'(i);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        #2;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt got %h want 00", drop_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        set_frame(16'h0100);
        in_valid = 10'h3FF;
        step();
        in_valid = '0;
        for (int i = 0; i < NN; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0100 + 16'(i) || out_last !== (i == NN-1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_word%0d got v=%b d=%h l=%b b=%b want v=1 d=%h l=%b b=1",
                         i, out_valid, out_data, out_last, busy, 16'h0100 + 16'(i), (i == NN-1));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end got v=%b l=%b b=%b want v=0 l=0 b=0", out_valid, out_last, busy);
        end
        checks++;
        if (out_data !== 16'h0109) begin errors++; $display("FAIL single_hold got %h want 0109", out_data); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d;
        set_frame(16'h0200);
        in_valid = 10'h001;
        step();
        in_valid = '0;
        for (int i = 0; i < 2*NN; i++) begin
            exp_d = (i < NN) ? 16'h0200 + 16'(i) : 16'h0300 + 16'(i - NN);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (i == NN-1 || i == 2*NN-1)) begin
                errors++;
                $display("FAIL b2b_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_d, (i == NN-1 || i == 2*NN-1));
            end
            if (i == NN-1) begin
                set_frame(16'h0300);
                in_valid = 10'h001;
            end else begin
                in_valid = '0;
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL b2b_end got v=%b drop=%h want v=0 drop=00", out_valid, drop_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [DW-1:0] exp_d;
        int n_exp;
        logic [DROP_W-1:0] exp_drop;
`ifdef SER_DBUF_EN
        n_exp = 2*NN;
        exp_drop = 8'h00;
`else
        n_exp = NN;
        exp_drop = 8'h01;
`endif
        set_frame(16'h0400);
        in_valid = 10'h3FF;
        step();
        in_valid = '0;
        for (int i = 0; i < n_exp; i++) begin
            exp_d = (i < NN) ? 16'h0400 + 16'(i) : 16'h0500 + 16'(i - NN);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (i == NN-1 || i == 2*NN-1)) begin
                errors++;
                $display("FAIL overlap_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         i, out_valid, out_data, out_last, exp_d, (i == NN-1 || i == 2*NN-1));
            end
            if (i == 2) begin
                set_frame(16'h0500);
                in_valid = 10'h3FF;
            end else begin
                in_valid = '0;
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overlap_end got v=%b b=%b want v=0 b=0", out_valid, busy);
        end
        checks++;
        if (drop_cnt !== exp_drop) begin
            errors++;
            $display("FAIL overlap_drop got %h want %h", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_capture_key();
        set_frame(16'h0600);
        in_valid = 10'h3FE;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL key_no_bit0 got v=%b b=%b want v=0 b=0", out_valid, busy);
        end
        in_valid = 10'h001;
        step();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0600) begin
            errors++;
            $display("FAIL key_bit0 got v=%b d=%h want v=1 d=0600", out_valid, out_data);
        end
        for (int i = 0; i < NN; i++) step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL key_end got v=%b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        int waited;
        in_valid = 10'h3FF;
        set_frame(16'h0A00);
        for (int i = 0; i < 400; i++) step();
        in_valid = '0;
        checks++;
        if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_drop got %h want ff", drop_cnt); end
        waited = 0;
        while (busy === 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_drain got v=%b b=%b after %0d cycles want v=0 b=0", out_valid, busy, waited);
        end
        checks++;
        if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold got %h want ff", drop_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        set_frame(16'h0700);
        in_valid = 10'h001;
        step();
        in_valid = '0;
        for (int i = 0; i < NN-1; i++) step();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 16'h0709) begin
            errors++;
            $display("FAIL rstmid_pre got v=%b l=%b d=%h want v=1 l=1 d=0709", out_valid, out_last, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async got v=%b l=%b b=%b drop=%h d=%h want all 0",
                     out_valid, out_last, busy, drop_cnt, out_data);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_resume got v=%b b=%b want v=0 b=0", out_valid, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overlap();
        test_capture_key();
        test_saturation();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
